iir_mem_server: RTL and testbench
=================================

IIR_MEM_SERVER -- requirements
Module: iir_mem_server

Interface
REQ-001 Parameter N, default 64, number of samples per frame (2..1024).
REQ-002 Parameter IW, default 6, index width, ceil(log2(N)).
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  single-cycle pulse, begins a frame from IDLE.
REQ-006 s_valid / s_ready / s_data  input / output / input  1/1/16  signed input-sample stream.
REQ-007 iir_rst  output  1  holds the filter in reset while high.
REQ-008 load  input  1  filter read enable.
REQ-009 RAddr  input  20  filter read address.
REQ-010 DIn  output  16  signed sample returned for RAddr.
REQ-011 WEN / WAddr / Yn  input  1/20/16  filter result write: enable, address, signed data.
REQ-012 data_done  output  1  all N results captured.
REQ-013 Finish  input  1  filter acknowledges completion.
REQ-014 m_valid / m_ready / m_data / m_last  output / input / output / output  1/1/16/1  result stream.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 wr_err  output  1  sticky flag, out-of-range write seen.

Function
REQ-017 Storage SHALL be two N x 16 arrays, in_mem and out_mem; states IDLE, LOAD, RUN, DRAIN.
REQ-018 IDLE: s_ready=0, iir_rst=1, m_valid=0; start -> LOAD; start SHALL clear the load index, drain index and wr_err.
REQ-019 start outside IDLE SHALL be ignored.
REQ-020 LOAD: s_ready=1, iir_rst=1; each s_valid&&s_ready cycle writes s_data to in_mem[idx], idx+1; the transfer at idx==N-1 -> RUN on the next edge, s_ready low from that cycle.
REQ-021 RUN: iir_rst=0 from the first RUN cycle; DIn SHALL be combinational, in_mem[RAddr] when load=1 and RAddr<N, otherwise 0.
REQ-022 Outside RUN, DIn SHALL be 0.
REQ-023 RUN: at an edge with WEN=1 and WAddr<N, out_mem[WAddr] <= Yn; with WEN=1 and WAddr>=N no write occurs and wr_err <= 1.
REQ-024 WEN outside RUN SHALL be ignored with no wr_err.
REQ-025 data_done SHALL be registered: rises the cycle after the write to WAddr==N-1 is captured, then stays high until RUN is left.
REQ-026 Finish=1 while data_done=1 -> DRAIN; Finish while data_done=0 SHALL be ignored.
REQ-027 DRAIN: iir_rst=1, data_done=0, m_valid=1, m_data=out_mem[ridx], m_last=(ridx==N-1); each m_valid&&m_ready advances ridx.
REQ-028 m_data and m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-029 The transfer with m_last=1 -> IDLE, m_valid low on the next cycle.
REQ-030 Result order SHALL be index 0..N-1; unwritten out_mem entries return their stale content, with no error.
REQ-031 Index counters SHALL be IW bits and never wrap inside a state; the terminal compare is against N-1.

Reset
REQ-032 rst=1 SHALL force, immediately and asynchronously: state IDLE, counters 0, s_ready=0, iir_rst=1, DIn=0, data_done=0, m_valid=0, m_data=0, m_last=0, busy=0, wr_err=0.
REQ-033 Memory arrays SHALL NOT be reset.
REQ-034 rst mid-frame SHALL discard the frame; the next start reloads from index 0.

Verification
REQ-035 N=64, start, stream 64 samples of value k at index k with s_valid held high -> s_ready drops after the 64th transfer; iir_rst=0 next cycle; RAddr=5, load=1 -> DIn=5.
REQ-036 RUN, RAddr=64 -> DIn=0; WEN=1, WAddr=70 -> no array change, wr_err=1 until next start.
REQ-037 WEN=1, WAddr=63, Yn=16'h1234 -> data_done=1 the next cycle; Finish=1 -> DRAIN, iir_rst=1, data_done=0.
REQ-038 DRAIN with m_ready alternating 1/0 -> 64 beats in index order; beat 63 carries 16'h1234 and m_last=1; data held during stalls; IDLE afterward.
REQ-039 rst pulse after 10 LOAD transfers -> all REQ-032 values immediately; new start plus 64 samples -> RUN reached normally.
REQ-040 start pulse in RUN, and Finish=1 before data_done -> no state change.

Source files
------------

// File: rtl/iir_mem_server.sv
// Frame buffer around an external IIR filter: loads N input samples, serves them to the filter,
// captures N results, then streams them out in index order.
module iir_mem_server #(
  parameter int N  = 64,
  parameter int IW = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic signed [15:0] s_data,
  output logic               iir_rst,
  input  logic               load,
  input  logic [19:0]        RAddr,
  output logic signed [15:0] DIn,
  input  logic               WEN,
  input  logic [19:0]        WAddr,
  input  logic signed [15:0] Yn,
  output logic               data_done,
  input  logic               Finish,
  output logic               m_valid,
  input  logic               m_ready,
  output logic signed [15:0] m_data,
  output logic               m_last,
  output logic               busy,
  output logic               wr_err
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  localparam logic [19:0]   N_A  = 20'(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [15:0]   in_mem  [N];
  logic [15:0]   out_mem [N];
  state_t        state, state_nxt;
  logic [IW-1:0] lidx, ridx;
  logic          s_fire, m_fire, w_ok, w_bad;

  assign s_fire = (state == LOAD) && s_valid;
  assign m_fire = (state == DRAIN) && m_ready;
  assign w_ok   = (state == RUN) && WEN && (WAddr < N_A);
  assign w_bad  = (state == RUN) && WEN && (WAddr >= N_A);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    iir_rst   = 1'b1;
    m_valid   = 1'b0;
    busy      = 1'b1;
    DIn       = '0;
    m_data    = '0;
    m_last    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_fire && lidx == LAST) state_nxt = RUN;
      end
      RUN: begin
        iir_rst = 1'b0;
        if (load && RAddr < N_A) DIn = in_mem[RAddr[IW-1:0]];
        if (Finish && data_done) state_nxt = DRAIN;
      end
      DRAIN: begin
        m_valid = 1'b1;
        m_data  = out_mem[ridx];
        m_last  = (ridx == LAST);
        if (m_fire && ridx == LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters saturate at the last index so they never wrap within a state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lidx      <= '0;
      ridx      <= '0;
      wr_err    <= 1'b0;
      data_done <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        lidx   <= '0;
        ridx   <= '0;
        wr_err <= 1'b0;
      end
      if (s_fire && lidx != LAST) lidx <= lidx + 1'b1;
      if (m_fire && ridx != LAST) ridx <= ridx + 1'b1;
      if (w_bad) wr_err <= 1'b1;
      if (state != RUN || state_nxt != RUN)
        data_done <= 1'b0;
      else if (w_ok && WAddr[IW-1:0] == LAST)
        data_done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (s_fire) in_mem[lidx] <= s_data;
    if (w_ok)   out_mem[WAddr[IW-1:0]] <= Yn;
  end
endmodule

// File: tb/tb_iir_mem_server.sv
// Bench for iir_mem_server: table-driven filter reads plus hand sequences for load, write,
// drain and reset, all checked against an array model of the two frame memories.
module tb_iir_mem_server;
  localparam int N = 64;

  logic        clk = 1'b0;
  logic        rst, start, s_valid, s_ready, iir_rst, load, WEN, data_done, Finish;
  logic        m_valid, m_ready, m_last, busy, wr_err;
  logic [15:0] s_data, DIn, Yn, m_data;
  logic [19:0] RAddr, WAddr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] in_model  [N];
  logic [15:0] out_model [N];

  typedef struct {
    logic        ld;
    logic [19:0] addr;
    logic [15:0] exp;
  } rd_vec_t;
  rd_vec_t rd_tab [8];

  iir_mem_server #(.N(N), .IW(6)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .iir_rst(iir_rst), .load(load), .RAddr(RAddr), .DIn(DIn),
    .WEN(WEN), .WAddr(WAddr), .Yn(Yn), .data_done(data_done), .Finish(Finish),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_s_ready"},   s_ready,   0);
    chk({tag, "_iir_rst"},   iir_rst,   1);
    chk({tag, "_DIn"},       DIn,       0);
    chk({tag, "_data_done"}, data_done, 0);
    chk({tag, "_m_valid"},   m_valid,   0);
    chk({tag, "_m_data"},    m_data,    0);
    chk({tag, "_m_last"},    m_last,    0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_wr_err"},    wr_err,    0);
  endtask

  // Holds s_valid high and feeds samples until cnt transfers have been accepted.
  task automatic stream(input int cnt, input bit use_k);
    int idx = 0;
    int cyc = 0;
    s_valid = 1'b1;
    while (idx < cnt && cyc < 400) begin
      s_data = use_k ? 16'(idx) : 16'($urandom);
      settle();
      if (s_ready) begin
        in_model[idx] = s_data;
        idx++;
      end
      step();
      cyc++;
    end
    chk("stream_count", idx, cnt);
  endtask

  task automatic run_reads(input string tag);
    rd_tab[0] = '{1'b1, 20'd0,     16'h0};
    rd_tab[1] = '{1'b1, 20'd5,     16'h0};
    rd_tab[2] = '{1'b1, 20'd63,    16'h0};
    rd_tab[3] = '{1'b1, 20'd64,    16'h0};
    rd_tab[4] = '{1'b1, 20'hFFFFF, 16'h0};
    rd_tab[5] = '{1'b0, 20'd5,     16'h0};
    rd_tab[6] = '{1'b1, 20'($urandom_range(0, N - 1)), 16'h0};
    rd_tab[7] = '{1'b1, 20'($urandom_range(0, N - 1)), 16'h0};
    for (int i = 0; i < 8; i++)
      rd_tab[i].exp = (rd_tab[i].ld && rd_tab[i].addr < N) ? in_model[rd_tab[i].addr[5:0]] : 16'h0;
    for (int i = 0; i < 8; i++) begin
      load  = rd_tab[i].ld;
      RAddr = rd_tab[i].addr;
      settle();
      chk($sformatf("%s_read%0d_addr%0h", tag, i, rd_tab[i].addr), DIn, rd_tab[i].exp);
      step();
    end
    load = 1'b0;
  endtask

  task automatic do_write(input logic [19:0] addr, input logic [15:0] val);
    WEN   = 1'b1;
    WAddr = addr;
    Yn    = val;
    step();
    WEN = 1'b0;
    if (addr < N) out_model[addr[5:0]] = val;
  endtask

  task automatic drain(input bit random_ready, input string tag);
    int got = 0;
    int cyc = 0;
    while (got < N && cyc < 600) begin
      m_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'(cyc % 2 == 0);
      settle();
      chk($sformatf("%s_valid%0d", tag, got), m_valid, 1);
      chk($sformatf("%s_data%0d", tag, got), m_data, out_model[got]);
      chk($sformatf("%s_last%0d", tag, got), m_last, 32'(got == N - 1));
      if (m_ready && m_valid) got++;
      step();
      cyc++;
    end
    m_ready = 1'b0;
    chk({tag, "_beats"}, got, N);
    settle();
    chk({tag, "_idle_valid"}, m_valid, 0);
    chk({tag, "_idle_busy"},  busy,    0);
    chk({tag, "_idle_iirrst"}, iir_rst, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; load = 1'b0; RAddr = '0;
    WEN = 1'b0; WAddr = '0; Yn = '0; Finish = 1'b0; m_ready = 1'b0;
    #1;
    check_reset_vals("por");
    step(); step();
    rst = 1'b0;
    step();
    settle();
    check_reset_vals("idle");
    step();

    // Frame 1: sample k at index k, every result written.
    start = 1'b1; step(); start = 1'b0;
    settle();
    chk("load_s_ready", s_ready, 1);
    chk("load_iir_rst", iir_rst, 1);
    chk("load_busy", busy, 1);
    step();
    stream(N, 1'b1);
    settle();
    chk("run_s_ready_low", s_ready, 0);
    chk("run_iir_rst", iir_rst, 0);
    load = 1'b1; RAddr = 20'd5;
    #1;
    chk("run_din5", DIn, 16'd5);
    step();
    s_valid = 1'b0;
    RAddr = 20'd64;
    settle();
    chk("run_din64", DIn, 0);
    step();
    load = 1'b0;
    for (int a = 0; a < N - 1; a++) do_write(20'(a), 16'($urandom));
    do_write(20'd70, 16'hDEAD);
    settle();
    chk("wr_err_set", wr_err, 1);
    chk("done_before_last", data_done, 0);
    step();
    Finish = 1'b1; step(); Finish = 1'b0;
    settle();
    chk("early_finish_iir_rst", iir_rst, 0);
    chk("early_finish_valid", m_valid, 0);
    step();
    start = 1'b1; step(); start = 1'b0;
    settle();
    chk("start_in_run_iir_rst", iir_rst, 0);
    chk("start_in_run_wr_err", wr_err, 1);
    step();
    run_reads("f1");
    WEN = 1'b1; WAddr = 20'd63; Yn = 16'h1234;
    settle();
    chk("done_pre_capture", data_done, 0);
    step();
    WEN = 1'b0;
    out_model[63] = 16'h1234;
    settle();
    chk("done_after_last", data_done, 1);
    step();
    Finish = 1'b1; step(); Finish = 1'b0;
    settle();
    chk("drain_iir_rst", iir_rst, 1);
    chk("drain_done_low", data_done, 0);
    chk("drain_valid", m_valid, 1);
    step();
    drain(1'b0, "f1");
    chk("wr_err_sticky", wr_err, 1);
    step();

    // Frame 2: start clears wr_err, WEN ignored outside RUN, reset mid-load.
    start = 1'b1; step(); start = 1'b0;
    settle();
    chk("start_clears_wr_err", wr_err, 0);
    step();
    WEN = 1'b1; WAddr = 20'd70; Yn = 16'hDEAD; load = 1'b1; RAddr = 20'd5;
    settle();
    chk("load_din_zero", DIn, 0);
    step();
    WAddr = 20'd3; Yn = 16'hBEEF;
    step();
    WEN = 1'b0; load = 1'b0;
    settle();
    chk("load_wen_no_err", wr_err, 0);
    step();
    stream(10, 1'b0);
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    step();
    rst = 1'b0;
    step();
    start = 1'b1; step(); start = 1'b0;
    stream(N, 1'b0);
    settle();
    chk("f2_s_ready_low", s_ready, 0);
    chk("f2_iir_rst", iir_rst, 0);
    step();
    s_valid = 1'b0;
    run_reads("f2");
    for (int a = 0; a < N - 1; a += 2) do_write(20'(a), 16'($urandom));
    do_write(20'd63, 16'($urandom));
    settle();
    chk("f2_done", data_done, 1);
    chk("f2_no_err", wr_err, 0);
    step();
    Finish = 1'b1; step(); Finish = 1'b0;
    drain(1'b1, "f2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
